// File: rtl/crc_pkg.sv
// Shared definitions for the dual-clock CRC engine: widths, field encodings,
// FSM encoding and the per-polynomial iteration counts of the clk_2 compute block.
package crc_pkg;

    localparam int MSG_W = 60;

    localparam logic CRC_SEL_CRC8 = 1'b0;
    localparam logic CRC_SEL_CRC5 = 1'b1;

    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    localparam int CRC5_ITERS = 28;
    localparam int CRC8_ITERS = 26;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } ctrl_state_e;

    // A check-mode result is all ones on mismatch, so its LSB is the failure flag.
    function automatic logic chk_fail_f(input logic mode, input logic result_lsb);
        return (mode == MODE_CHK) & result_lsb;
    endfunction

endpackage

// File: rtl/crc_clk1_ctrl_sync.sv
// Level synchroniser for an asynchronous toggle; depth set by STAGES (>= 2).
module cdc_sync2 #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else if (srst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/crc_clk1_ctrl.sv
// clk_1 front end of the dual-clock CRC engine: accepts one job at a time,
// launches it with a toggle request and returns the clk_2 result as a strobe.
module crc_clk1_ctrl
    import crc_pkg::*;
#(
    parameter int MSG_W       = crc_pkg::MSG_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_1,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [MSG_W-1:0] in_message,
    input  logic             in_CRC,
    input  logic             in_mode,
    output logic             in_ready,
    output logic [MSG_W-1:0] clk1_message,
    output logic             clk1_CRC,
    output logic             clk1_mode,
    output logic             clk1_flag,
    input  logic [MSG_W-1:0] clk2_out,
    input  logic             clk2_flag,
    output logic             out_valid,
    output logic [MSG_W-1:0] out_data,
    output logic             out_chk_fail,
    output logic             drop_pulse
);

    ctrl_state_e state_r;
    ctrl_state_e state_nxt_s;
    logic        rst_n_s;
    logic        ack_lvl_s;
    logic        accept_s;
    logic        done_s;
    logic        drop_s;

    assign rst_n_s = ~rst;

    cdc_sync2 #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk_1),
        .rst_n (rst_n_s),
        .srst  (1'b0),
        .d     (clk2_flag),
        .q     (ack_lvl_s)
    );

    // Next-state and event decode; completion is a level-parity match, not an edge.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        done_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_WAIT_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (ack_lvl_s == clk1_flag) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_ACK;
                end
                if (in_valid) begin
                    drop_s = 1'b1;
                end else begin
                    drop_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign in_ready = (state_r == ST_IDLE);

    // FSM state register.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job registers and request toggle; held untouched until the next accept.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            clk1_message <= {MSG_W{1'b0}};
            clk1_CRC     <= 1'b0;
            clk1_mode    <= 1'b0;
            clk1_flag    <= 1'b0;
        end else if (accept_s) begin
            clk1_message <= in_message;
            clk1_CRC     <= in_CRC;
            clk1_mode    <= in_mode;
            clk1_flag    <= ~clk1_flag;
        end
    end

    // Result capture and one-cycle strobes.
    always_ff @(posedge clk_1 or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= {MSG_W{1'b0}};
            out_chk_fail <= 1'b0;
            drop_pulse   <= 1'b0;
        end else begin
            out_valid  <= done_s;
            drop_pulse <= drop_s;
            if (done_s) begin
                out_data     <= clk2_out;
                out_chk_fail <= chk_fail_f(clk1_mode, clk2_out[0]);
            end
        end
    end

endmodule

// File: tb/tb_crc_clk1_ctrl.sv
// Self-checking bench: behavioural clk_2 responder, CRC reference model,
// table-driven plus random jobs, and hand-written back-to-back/drop/reset cases.
module tb_crc_clk1_ctrl;
    import crc_pkg::*;

    logic        clk_1, clk_2, rst;
    logic        in_valid, in_CRC, in_mode, in_ready;
    logic [59:0] in_message, clk1_message, clk2_out, out_data;
    logic        clk1_CRC, clk1_mode, clk1_flag, clk2_flag;
    logic        out_valid, out_chk_fail, drop_pulse;

    int checks = 0;
    int failures = 0;

    crc_clk1_ctrl #(.MSG_W(60), .SYNC_STAGES(2)) dut (
        .clk_1(clk_1), .rst(rst), .in_valid(in_valid), .in_message(in_message),
        .in_CRC(in_CRC), .in_mode(in_mode), .in_ready(in_ready),
        .clk1_message(clk1_message), .clk1_CRC(clk1_CRC), .clk1_mode(clk1_mode),
        .clk1_flag(clk1_flag), .clk2_out(clk2_out), .clk2_flag(clk2_flag),
        .out_valid(out_valid), .out_data(out_data), .out_chk_fail(out_chk_fail),
        .drop_pulse(drop_pulse)
    );

    initial begin clk_1 = 1'b0; forever #5 clk_1 = ~clk_1; end
    initial begin clk_2 = 1'b0; forever #7 clk_2 = ~clk_2; end

    // Reference CRC: polynomial long division over the relevant message bits.
    function automatic logic [59:0] crc_job(input logic [59:0] m, input logic sel, input logic mode);
        logic [7:0] poly, msk, r;
        int w, nb;
        logic fb;
        w    = (sel == CRC_SEL_CRC5) ? 5 : 8;
        poly = (sel == CRC_SEL_CRC5) ? 8'h05 : 8'h07;
        msk  = (sel == CRC_SEL_CRC5) ? 8'h1F : 8'hFF;
        nb   = (mode == MODE_CHK) ? 60 : 60 - w;
        r    = 8'h00;
        for (int i = nb - 1; i >= 0; i--) begin
            fb = m[i] ^ r[w-1];
            r  = (r << 1) & msk;
            if (fb) r = r ^ poly;
        end
        if (mode == MODE_CHK) return (r != 8'h00) ? {60{1'b1}} : 60'h0;
        if (sel == CRC_SEL_CRC5) return {m[54:0], r[4:0]};
        return {m[51:0], r};
    endfunction

    // Behavioural clk_2 block: sync the request, compute for a while, toggle back.
    logic [1:0] req_sync;
    logic       busy2;
    int         cnt2;
    always @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            req_sync <= 2'b00; busy2 <= 1'b0; cnt2 <= 0;
            clk2_out <= 60'h0; clk2_flag <= 1'b0;
        end else begin
            req_sync <= {req_sync[0], clk1_flag};
            if (busy2) begin
                if (cnt2 == 0) begin
                    clk2_out  <= crc_job(clk1_message, clk1_CRC, clk1_mode);
                    clk2_flag <= ~clk2_flag;
                    busy2     <= 1'b0;
                end else begin
                    cnt2 <= cnt2 - 1;
                end
            end else if (req_sync[1] != clk2_flag) begin
                busy2 <= 1'b1;
                cnt2  <= 4 + ((clk1_CRC == CRC_SEL_CRC5) ? CRC5_ITERS : CRC8_ITERS);
            end
        end
    end

    typedef struct {
        logic [59:0] data;
        logic        fail;
        logic        rdy;
    } obs_t;
    obs_t obs_q[$];
    int   drop_cnt = 0;

    // Result/drop monitor sampled just after the active edge.
    always @(posedge clk_1) begin
        obs_t o;
        #1;
        if (!rst) begin
            if (out_valid) begin
                o.data = out_data; o.fail = out_chk_fail; o.rdy = in_ready;
                obs_q.push_back(o);
            end
            if (drop_pulse) drop_cnt++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    logic model_flag = 1'b0;

    task automatic apply_reset();
        @(negedge clk_1);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk_1);
        check("rst_flag", {63'd0, clk1_flag}, 64'd0);
        check("rst_ready", {63'd0, in_ready}, 64'd1);
        check("rst_outs", {61'd0, out_valid, out_chk_fail, drop_pulse}, 64'd0);
        check("rst_data", {4'd0, out_data}, 64'd0);
        check("rst_job", {2'd0, clk1_message, clk1_CRC, clk1_mode}, 64'd0);
        #2 rst = 1'b0;
        model_flag = 1'b0;
        obs_q.delete();
        repeat (2) @(negedge clk_1);
        check("post_rst_ready", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic send_job(input logic [59:0] m, input logic sel, input logic mode);
        @(negedge clk_1);
        check("ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_message = m; in_CRC = sel; in_mode = mode;
        @(negedge clk_1);
        in_valid = 1'b0;
        model_flag = ~model_flag;
        check("req_flag", {63'd0, clk1_flag}, {63'd0, model_flag});
        check("job_msg", {4'd0, clk1_message}, {4'd0, m});
        check("job_sel_mode", {62'd0, clk1_CRC, clk1_mode}, {62'd0, sel, mode});
    endtask

    task automatic wait_result(output obs_t o, output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_1);
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_job(input logic [59:0] m, input logic sel, input logic mode,
                           input logic [59:0] exp_d, input logic exp_f);
        obs_t o;
        bit got;
        send_job(m, sel, mode);
        wait_result(o, got);
        check("result_timeout", {63'd0, got}, 64'd1);
        if (got) begin
            check("out_data", {4'd0, o.data}, {4'd0, exp_d});
            check("out_chk_fail", {63'd0, o.fail}, {63'd0, exp_f});
            check("ready_in_valid_cycle", {63'd0, o.rdy}, 64'd1);
        end
    endtask

    typedef struct {
        logic [59:0] msg;
        logic        sel;
        logic        mode;
        logic [59:0] exp_data;
        logic        exp_fail;
    } vec_t;
    vec_t vecs[6];

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [59:0] m, b2b_msg[3], b2b_exp[3], base;
        logic        sel, mode;
        obs_t        o;
        bit          got;
        int          d0;

        rst = 1'b0; in_valid = 1'b0; in_message = 60'h0; in_CRC = 1'b0; in_mode = 1'b0;

        base = {8'hA5, 20'h3C5A1, $urandom()};
        vecs[0] = '{60'h0, CRC_SEL_CRC5, MODE_CHK, 60'h0, 1'b0};
        vecs[1] = '{60'h1, CRC_SEL_CRC5, MODE_CHK, 60'hFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[2] = '{base, CRC_SEL_CRC8, MODE_GEN, crc_job(base, CRC_SEL_CRC8, MODE_GEN), 1'b0};
        vecs[3] = '{vecs[2].exp_data, CRC_SEL_CRC8, MODE_CHK, 60'h0, 1'b0};
        vecs[4] = '{vecs[2].exp_data ^ 60'h10, CRC_SEL_CRC8, MODE_CHK, {60{1'b1}}, 1'b1};
        vecs[5] = '{{8'h00, base[51:0]}, CRC_SEL_CRC8, MODE_GEN, vecs[2].exp_data, 1'b0};

        apply_reset();

        for (int i = 0; i < 6; i++)
            run_job(vecs[i].msg, vecs[i].sel, vecs[i].mode, vecs[i].exp_data, vecs[i].exp_fail);

        for (int i = 0; i < 8; i++) begin
            m    = {$urandom(), $urandom()};
            sel  = $urandom_range(0, 1);
            mode = $urandom_range(0, 1);
            if (mode == MODE_CHK && $urandom_range(0, 1) == 1)
                m = crc_job(m, sel, MODE_GEN);
            run_job(m, sel, mode, crc_job(m, sel, mode),
                    (mode == MODE_CHK) && (crc_job(m, sel, mode) != 60'h0));
        end

        // Back-to-back: each new job accepted in the previous job's out_valid cycle.
        apply_reset();
        d0 = drop_cnt;
        for (int k = 0; k < 3; k++) begin
            b2b_msg[k] = {$urandom(), $urandom()};
            b2b_exp[k] = crc_job(b2b_msg[k], CRC_SEL_CRC5, MODE_GEN);
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk_1);
                if (in_ready) got = 1'b1;
            end
            check("b2b_ready_timeout", {63'd0, got}, 64'd1);
            if (k > 0) check("b2b_same_cycle", {63'd0, out_valid}, 64'd1);
            in_valid = 1'b1; in_message = b2b_msg[k]; in_CRC = CRC_SEL_CRC5; in_mode = MODE_GEN;
            @(negedge clk_1);
            in_valid = 1'b0;
            model_flag = ~model_flag;
            check("b2b_flag", {63'd0, clk1_flag}, {63'd0, model_flag});
        end
        for (int i = 0; i < 200 && obs_q.size() < 3; i++) @(negedge clk_1);
        repeat (3) @(negedge clk_1);
        check("b2b_count", obs_q.size(), 64'd3);
        for (int k = 0; k < 3 && obs_q.size() > 0; k++) begin
            o = obs_q.pop_front();
            check("b2b_data", {4'd0, o.data}, {4'd0, b2b_exp[k]});
        end
        check("b2b_no_drop", drop_cnt, d0);

        // Rejected job while waiting for the acknowledge.
        m = {$urandom(), $urandom()};
        send_job(m, CRC_SEL_CRC8, MODE_GEN);
        d0 = drop_cnt;
        in_valid = 1'b1; in_message = ~m; in_CRC = CRC_SEL_CRC5; in_mode = MODE_CHK;
        @(negedge clk_1);
        in_valid = 1'b0;
        repeat (2) @(negedge clk_1);
        check("drop_count", drop_cnt, d0 + 1);
        check("drop_msg_held", {4'd0, clk1_message}, {4'd0, m});
        check("drop_sel_mode_held", {62'd0, clk1_CRC, clk1_mode}, {62'd0, CRC_SEL_CRC8, MODE_GEN});
        check("drop_flag_held", {63'd0, clk1_flag}, {63'd0, model_flag});
        wait_result(o, got);
        check("drop_result_timeout", {63'd0, got}, 64'd1);
        if (got) check("drop_result", {4'd0, o.data}, {4'd0, crc_job(m, CRC_SEL_CRC8, MODE_GEN)});

        // Reset while a job is outstanding: no result may follow.
        send_job({$urandom(), $urandom()}, CRC_SEL_CRC5, MODE_GEN);
        repeat (5) @(negedge clk_1);
        apply_reset();
        repeat (150) @(negedge clk_1);
        check("no_valid_after_rst", obs_q.size(), 64'd0);
        check("idle_after_rst", {62'd0, in_ready, clk1_flag}, 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
